// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared constants and state encoding for the UART register
//               bridge: host command bytes, response bytes, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

   // Host command bytes
   localparam logic [7:0] C_CMD_WR  = 8'h57;   // 'W'
   localparam logic [7:0] C_CMD_RD  = 8'h52;   // 'R'

   // Response bytes
   localparam logic [7:0] C_RSP_OK  = 8'h4B;   // 'K'
   localparam logic [7:0] C_RSP_ERR = 8'h45;   // 'E'
   localparam logic [7:0] C_RSP_UNK = 8'h3F;   // '?'

   // Bridge states. The top owns IDLE..BUS_RD and uses WAIT_TX to mean
   // "response in progress"; uart_resp_tx walks WAIT_TX/RESP/HOLD itself.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_DATA    = 3'd2,
      ST_BUS_WR  = 3'd3,
      ST_BUS_RD  = 3'd4,
      ST_WAIT_TX = 3'd5,
      ST_RESP    = 3'd6,
      ST_HOLD    = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_resp_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_resp_tx
// Description : Response sequencer. Buffers a 1- or 4-byte response, waits
//               for the UART TX FIFO to be empty, streams the bytes back to
//               back, then holds 2 cycles to ride out the FIFO flag lag.
// Ports       : clk, reset      - clock, async active-high reset
//               i_load          - one-cycle request to queue a response
//               i_len4          - 1: four bytes, 0: one byte
//               i_bytes         - response bytes, byte 0 in [7:0]
//               i_tx_empty      - UART TX FIFO empty flag
//               o_tx_data/valid - byte write to the UART TX FIFO
//               o_done          - last HOLD cycle, sequencer returns to idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_tx
   import uart_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_len4,
   input  logic [31:0] i_bytes,
   input  logic        i_tx_empty,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   output logic        o_done
);

   state_t      r_state;
   logic [31:0] r_buf;
   logic [1:0]  r_rem;       // bytes still to send after the one on the bus
   logic        r_hold;
   logic [7:0]  r_tx_data;
   logic        r_tx_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_buf      <= '0;
         r_rem      <= '0;
         r_hold     <= 1'b0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_load) begin
                  r_buf   <= i_bytes;
                  r_rem   <= i_len4 ? 2'd3 : 2'd0;
                  r_state <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               if (i_tx_empty) begin
                  r_tx_data  <= r_buf[7:0];
                  r_tx_valid <= 1'b1;
                  r_buf      <= {8'h00, r_buf[31:8]};
                  r_state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (r_rem == 2'd0) begin
                  r_tx_valid <= 1'b0;
                  r_hold     <= 1'b0;
                  r_state    <= ST_HOLD;
               end else begin
                  r_tx_data <= r_buf[7:0];
                  r_buf     <= {8'h00, r_buf[31:8]};
                  r_rem     <= r_rem - 2'd1;
               end
            end
            ST_HOLD: begin
               // Fixed two cycles; i_tx_empty may still show the old value.
               if (r_hold) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_hold <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_valid = r_tx_valid;
   assign o_done     = (r_state == ST_HOLD) && r_hold;

endmodule
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_bridge
// Description : Decodes 'W'/'R' command packets from the UART receiver,
//               performs 32-bit register writes/reads on the internal bus
//               and queues the response to the UART transmitter.
// Ports       : clk, reset            - clock, async active-high reset
//               i_rx_data/i_rx_valid  - received byte strobe
//               o_tx_data/o_tx_valid  - response byte write strobe
//               i_tx_empty            - TX FIFO empty flag
//               o_addr/o_wdata        - register address / write data
//               o_we/o_re             - one-cycle bus strobes
//               i_rdata/i_rvalid      - read return
//               o_busy                - not IDLE
//               o_overrun             - sticky dropped-byte flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge
   import uart_bridge_pkg::*;
#(
   parameter logic [15:0] TIMEOUT    = 16'd50000,
   parameter logic [7:0]  RD_TIMEOUT = 8'd64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_empty,
   output logic [7:0]  o_addr,
   output logic [31:0] o_wdata,
   output logic        o_we,
   output logic        o_re,
   input  logic [31:0] i_rdata,
   input  logic        i_rvalid,
   output logic        o_busy,
   output logic        o_overrun
);

   state_t      r_state;
   logic [7:0]  r_cmd;
   logic [1:0]  r_idx;
   logic [15:0] r_to_cnt;
   logic [7:0]  r_rd_cnt;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic        r_re;
   logic        r_overrun;

   logic        w_is_cmd;
   logic        w_load;
   logic        w_len4;
   logic [31:0] w_bytes;
   logic        w_tx_done;

   assign w_is_cmd = (i_rx_data == C_CMD_WR) || (i_rx_data == C_CMD_RD);

   // Response request, raised on the same cycle the FSM moves to WAIT_TX.
   always_comb begin
      w_load  = 1'b0;
      w_len4  = 1'b0;
      w_bytes = {24'h0, C_RSP_UNK};
      case (r_state)
         ST_IDLE: begin
            if (i_rx_valid && !w_is_cmd) begin
               w_load = 1'b1;
            end
         end
         ST_BUS_WR: begin
            w_load  = 1'b1;
            w_bytes = {24'h0, C_RSP_OK};
         end
         ST_BUS_RD: begin
            // r_re marks the strobe cycle, where i_rvalid is not yet valid.
            // Data beats the timeout when both land on the same cycle.
            if (!r_re && i_rvalid) begin
               w_load  = 1'b1;
               w_len4  = 1'b1;
               w_bytes = i_rdata;
            end else if (r_rd_cnt == RD_TIMEOUT) begin
               w_load  = 1'b1;
               w_bytes = {24'h0, C_RSP_ERR};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cmd    <= '0;
         r_idx    <= '0;
         r_to_cnt <= '0;
         r_rd_cnt <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  if (w_is_cmd) begin
                     r_cmd    <= i_rx_data;
                     r_to_cnt <= '0;
                     r_state  <= ST_ADDR;
                  end else begin
                     r_state <= ST_WAIT_TX;
                  end
               end
            end
            ST_ADDR: begin
               if (i_rx_valid) begin
                  r_addr   <= i_rx_data;
                  r_to_cnt <= '0;
                  if (r_cmd == C_CMD_WR) begin
                     r_idx   <= '0;
                     r_state <= ST_DATA;
                  end else begin
                     r_re     <= 1'b1;
                     r_rd_cnt <= '0;
                     r_state  <= ST_BUS_RD;
                  end
               end else if (r_to_cnt == TIMEOUT) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
            end
            ST_DATA: begin
               if (i_rx_valid) begin
                  r_wdata[{r_idx, 3'b000} +: 8] <= i_rx_data;
                  r_to_cnt <= '0;
                  if (r_idx == 2'd3) begin
                     r_we    <= 1'b1;
                     r_state <= ST_BUS_WR;
                  end else begin
                     r_idx <= r_idx + 2'd1;
                  end
               end else if (r_to_cnt == TIMEOUT) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 16'd1;
               end
            end
            ST_BUS_WR: begin
               r_we    <= 1'b0;
               r_state <= ST_WAIT_TX;
            end
            ST_BUS_RD: begin
               r_re     <= 1'b0;
               r_rd_cnt <= r_rd_cnt + 8'd1;
               if (w_load) begin
                  r_state <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               // Covers WAIT_TX, RESP and HOLD inside uart_resp_tx.
               if (w_tx_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else if (i_rx_valid && (r_state == ST_BUS_WR || r_state == ST_BUS_RD ||
                                  r_state == ST_WAIT_TX)) begin
         r_overrun <= 1'b1;
      end
   end

   uart_resp_tx u_resp_tx (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_len4     (w_len4),
      .i_bytes    (w_bytes),
      .i_tx_empty (i_tx_empty),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .o_done     (w_tx_done)
   );

   assign o_addr    = r_addr;
   assign o_wdata   = r_wdata;
   assign o_we      = r_we;
   assign o_re      = r_re;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_bridge
// Description : Directed self-checking bench for uart_reg_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_reg_bridge;

   localparam logic [15:0] C_TO  = 16'd300;
   localparam logic [7:0]  C_RTO = 8'd64;

   logic        clk;
   logic        reset;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_empty;
   logic [7:0]  o_addr;
   logic [31:0] o_wdata;
   logic        o_we;
   logic        o_re;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic        o_busy;
   logic        o_overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int we_cnt  = 0;
   int re_cnt  = 0;
   int re_cyc  = 0;
   int base    = 0;
   int we_base = 0;
   int re_base = 0;
   logic [7:0] tx_q[$];
   int         tx_cyc[$];

   uart_reg_bridge #(
      .TIMEOUT    (C_TO),
      .RD_TIMEOUT (C_RTO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_rx_data  (i_rx_data),
      .i_rx_valid (i_rx_valid),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_empty (i_tx_empty),
      .o_addr     (o_addr),
      .o_wdata    (o_wdata),
      .o_we       (o_we),
      .o_re       (o_re),
      .i_rdata    (i_rdata),
      .i_rvalid   (i_rvalid),
      .o_busy     (o_busy),
      .o_overrun  (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Mid-cycle monitor of DUT strobes
   always @(negedge clk) begin
      if (o_tx_valid) begin
         tx_q.push_back(o_tx_data);
         tx_cyc.push_back(cyc);
      end
      if (o_we) we_cnt++;
      if (o_re) begin
         re_cnt++;
         re_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, required %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'h00;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (o_busy && n < limit) begin
         tick();
         n++;
      end
      check(tag, {31'h0, o_busy}, 32'h0);
   endtask

   task automatic mark();
      base    = tx_q.size();
      we_base = we_cnt;
      re_base = re_cnt;
   endtask

   function automatic logic [7:0] txb(input int i);
      if (tx_q.size() > base + i) return tx_q[base + i];
      return 8'hxx;
   endfunction

   function automatic int txn();
      return tx_q.size() - base;
   endfunction

   initial begin
      reset      = 1'b1;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      i_tx_empty = 1'b1;
      i_rdata    = 32'h0;
      i_rvalid   = 1'b0;
      tick();
      tick();
      check("rst_busy",    {31'h0, o_busy},     32'h0);
      check("rst_strobes", {29'h0, o_we, o_re, o_tx_valid}, 32'h0);
      check("rst_overrun", {31'h0, o_overrun},  32'h0);
      check("rst_addr",    {24'h0, o_addr},     32'h0);
      check("rst_wdata",   o_wdata,             32'h0);
      reset = 1'b0;
      tick();

      // Write 0xDEADBEEF to 0x10: o_we the cycle after the D3 strobe
      mark();
      send_byte(8'h57); send_byte(8'h10); send_byte(8'hEF);
      send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      check("wr_we",    {31'h0, o_we}, 32'h1);
      check("wr_addr",  {24'h0, o_addr}, 32'h10);
      check("wr_wdata", o_wdata, 32'hDEADBEEF);
      wait_idle("wr_idle", 50);
      check("wr_we_cnt", we_cnt - we_base, 1);
      check("wr_tx_n",   txn(), 1);
      check("wr_tx_k",   {24'h0, txb(0)}, 32'h4B);

      // Read 0x20, data 3 cycles after o_re
      mark();
      send_byte(8'h52); send_byte(8'h20);
      check("rd_re", {31'h0, o_re}, 32'h1);
      check("rd_addr", {24'h0, o_addr}, 32'h20);
      tick(); tick(); tick();
      i_rdata = 32'h12345678; i_rvalid = 1'b1;
      tick();
      i_rvalid = 1'b0; i_rdata = 32'h0;
      wait_idle("rd_idle", 50);
      check("rd_tx_n", txn(), 4);
      check("rd_tx_bytes", {txb(0), txb(1), txb(2), txb(3)}, 32'h78563412);
      check("rd_tx_b2b", (txn() == 4) ? tx_cyc[base + 3] - tx_cyc[base] : -1, 3);
      check("rd_re_cnt", re_cnt - re_base, 1);

      // Read 0x30, no i_rvalid: 'E' queued RD_TIMEOUT cycles after o_re,
      // WAIT_TX sees empty one cycle later, byte goes out the cycle after.
      mark();
      send_byte(8'h52); send_byte(8'h30);
      wait_idle("rto_idle", 200);
      check("rto_tx_n", txn(), 1);
      check("rto_tx_e", {24'h0, txb(0)}, 32'h45);
      check("rto_delay", (txn() == 1) ? tx_cyc[base] - re_cyc : -1, int'(C_RTO) + 2);
      check("rto_strobes", (re_cnt - re_base) + (we_cnt - we_base), 1);

      // i_rvalid on the expiry cycle: data wins over 'E'
      mark();
      send_byte(8'h52); send_byte(8'h31);
      repeat (int'(C_RTO)) tick();
      i_rdata = 32'hA1B2C3D4; i_rvalid = 1'b1;
      tick();
      i_rvalid = 1'b0; i_rdata = 32'h0;
      wait_idle("rdx_idle", 50);
      check("rdx_tx_n", txn(), 4);
      check("rdx_bytes", {txb(0), txb(1), txb(2), txb(3)}, 32'hD4C3B2A1);

      // Unknown command
      mark();
      send_byte(8'h41);
      wait_idle("unk_idle", 50);
      check("unk_tx", {24'h0, txb(0)}, 32'h3F);
      check("unk_tx_n", txn(), 1);
      check("unk_strobes", (re_cnt - re_base) + (we_cnt - we_base), 0);

      // Inter-byte timeout: partial write discarded silently
      mark();
      send_byte(8'h57); send_byte(8'h10); send_byte(8'hAA);
      repeat (int'(C_TO) + 20) tick();
      check("to_busy", {31'h0, o_busy}, 32'h0);
      check("to_no_tx", txn(), 0);
      check("to_no_we", we_cnt - we_base, 0);
      send_byte(8'h52); send_byte(8'h10);
      tick();
      i_rdata = 32'hCAFEF00D; i_rvalid = 1'b1;
      tick();
      i_rvalid = 1'b0; i_rdata = 32'h0;
      wait_idle("to_rd_idle", 50);
      check("to_rd_bytes", {txb(0), txb(1), txb(2), txb(3)}, 32'h0DF0FECA);

      // Byte on the timeout expiry cycle is still accepted
      mark();
      send_byte(8'h57);
      repeat (int'(C_TO)) tick();
      send_byte(8'h11);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("tox_we", {31'h0, o_we}, 32'h1);
      check("tox_wdata", o_wdata, 32'h04030201);
      check("tox_addr", {24'h0, o_addr}, 32'h11);
      wait_idle("tox_idle", 50);

      // Overrun while waiting for the TX FIFO
      mark();
      i_tx_empty = 1'b0;
      send_byte(8'h41);
      send_byte(8'h55);
      check("ovr_set", {31'h0, o_overrun}, 32'h1);
      repeat (10) tick();
      check("ovr_hold_tx", txn(), 0);
      i_tx_empty = 1'b1;
      wait_idle("ovr_idle", 50);
      check("ovr_tx", {24'h0, txb(0)}, 32'h3F);
      check("ovr_sticky", {31'h0, o_overrun}, 32'h1);

      // Reset mid-read: strobe and overrun cleared asynchronously
      mark();
      send_byte(8'h52); send_byte(8'h40);
      check("mid_re", {31'h0, o_re}, 32'h1);
      reset = 1'b1;
      #1;
      check("mid_rst_re", {31'h0, o_re}, 32'h0);
      check("mid_rst_ovr", {31'h0, o_overrun}, 32'h0);
      check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
      tick();
      reset = 1'b0;
      repeat (int'(C_RTO) + 20) tick();
      check("mid_no_tx", txn(), 0);
      check("mid_idle", {31'h0, o_busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
